// File: rtl/dp_pkg.sv
`default_nettype none
// ============================================================================
// Module : dp_pkg
// Brief  : Shared widths, state encodings and field indices for dp_pipe_stage.
// Rev    : 1.0
// ============================================================================
package dp_pkg;

  localparam int DP_W        = 32;
  localparam int DP_N_FIELDS = 3;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam int F_X   = 0;
  localparam int F_NUM = 1;
  localparam int F_SUM = 2;

endpackage
`default_nettype wire

// File: rtl/dp_entry_reg.sv
`default_nettype none
// ============================================================================
// Module : dp_entry_reg
// Brief  : One buffered beat {overflow, fields} with load enable and sync clear.
// Rev    : 1.0
// ============================================================================
module dp_entry_reg
  import dp_pkg::*;
#(
  parameter int WIDTH = DP_N_FIELDS * DP_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/dp_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module : dp_pipe_stage
// Brief  : Elastic valid/ready pipeline register with 2-entry skid buffer and
//          synchronous flush. Define DP_PIPE_OVF_STICKY_EN for sticky overflow.
// Rev    : 1.0
// ============================================================================
module dp_pipe_stage
  import dp_pkg::*;
#(
  parameter int W        = DP_W,
  parameter int N_FIELDS = DP_N_FIELDS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_FIELDS*W-1:0] in_data,
  input  logic                  in_overflow,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_FIELDS*W-1:0] out_data,
  output logic                  out_overflow,
  output logic [1:0]            occupancy
);

  localparam int c_EW = N_FIELDS * W + 1;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic            w_it;
  logic            w_ot;
  logic            w_main_load;
  logic            w_skid_load;
  logic [c_EW-1:0] w_in_entry;
  logic [c_EW-1:0] w_main_d;
  logic [c_EW-1:0] w_main_q;
  logic [c_EW-1:0] w_skid_q;

  assign in_ready   = (r_state != ST_FULL) & ~rst & ~flush;
  assign out_valid  = (r_state != ST_EMPTY);
  assign w_it       = in_valid & in_ready;
  assign w_ot       = out_valid & out_ready;
  assign w_in_entry = {in_overflow, in_data};

  always_comb begin
    w_state_nxt = r_state;
    w_main_load = 1'b0;
    w_skid_load = 1'b0;
    w_main_d    = w_in_entry;
    occupancy   = 2'd0;
    case (r_state)
      ST_EMPTY: begin
        occupancy = 2'd0;
        if (w_it) begin
          w_main_load = 1'b1;
          w_state_nxt = ST_ONE;
        end
      end
      ST_ONE: begin
        occupancy = 2'd1;
        if (w_it && w_ot) begin
          w_main_load = 1'b1;
        end else if (w_it) begin
          w_skid_load = 1'b1;
          w_state_nxt = ST_FULL;
        end else if (w_ot) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        occupancy = 2'd2;
        // Skid beat was accepted after main, so it becomes the new head.
        w_main_d = w_skid_q;
        if (w_ot) begin
          w_main_load = 1'b1;
          w_state_nxt = ST_ONE;
        end
      end
      default: begin
        occupancy   = 2'd0;
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  dp_entry_reg #(.WIDTH(c_EW)) u_main (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .load (w_main_load),
    .d    (w_main_d),
    .q    (w_main_q)
  );

  dp_entry_reg #(.WIDTH(c_EW)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .load (w_skid_load),
    .d    (w_in_entry),
    .q    (w_skid_q)
  );

  assign out_data = w_main_q[c_EW-2:0];

`ifdef DP_PIPE_OVF_STICKY_EN
  logic r_ovf_sticky;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_ovf_sticky <= 1'b0;
    end else if (w_ot && w_main_q[c_EW-1]) begin
      r_ovf_sticky <= 1'b1;
    end
  end

  assign out_overflow = w_main_q[c_EW-1] | r_ovf_sticky;
`else
  assign out_overflow = w_main_q[c_EW-1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_dp_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_dp_pipe_stage
// Brief  : Directed table-driven bench for dp_pipe_stage plus a streaming run.
// Rev    : 1.0
// ============================================================================
module tb_dp_pipe_stage;

  localparam int W  = 32;
  localparam int NF = 3;
  localparam int DW = NF * W;
  localparam int NV = 21;

`ifdef DP_PIPE_OVF_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  typedef struct {
    logic          rst;
    logic          flush;
    logic          iv;
    logic [DW-1:0] d;
    logic          ovf;
    logic          ordy;
    logic          e_ov;
    logic          e_ir;
    logic [1:0]    e_occ;
    logic          chk_d;
    logic [DW-1:0] e_d;
    logic          e_oo;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_overflow;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_overflow;
  logic [1:0]    occupancy;

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  dp_pipe_stage #(.W(W), .N_FIELDS(NF)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_overflow  (in_overflow),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_overflow (out_overflow),
    .occupancy    (occupancy)
  );

  function automatic logic [DW-1:0] pk(input int x, input int num, input int sum);
    pk = {sum[W-1:0], num[W-1:0], x[W-1:0]};
  endfunction

  function automatic logic [DW-1:0] mk(input int k);
    mk = pk(k + 200, k + 100, k);
  endfunction

  function automatic vec_t v(input logic r, input logic f, input logic iv,
                             input logic [DW-1:0] d, input logic ovf, input logic ordy,
                             input logic e_ov, input logic e_ir, input logic [1:0] e_occ,
                             input logic chk_d, input logic [DW-1:0] e_d, input logic e_oo);
    v = '{r, f, iv, d, ovf, ordy, e_ov, e_ir, e_occ, chk_d, e_d, e_oo};
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [DW-1:0] d, input logic ovf, input logic ordy);
    rst         = r;
    flush       = f;
    in_valid    = iv;
    in_data     = d;
    in_overflow = ovf;
    out_ready   = ordy;
  endtask

  initial begin
    // Expected values describe outputs in the cycle the row is driven (pre-edge).
    vecs[0]  = v(1, 0, 1, pk(9, 9, 9), 1, 1,  0, 0, 2'd0, 1, '0, 0);
    vecs[1]  = v(0, 0, 1, pk(5, 3, 7), 0, 1,  0, 1, 2'd0, 1, '0, 0);
    vecs[2]  = v(0, 0, 0, '0, 0, 1,           1, 1, 2'd1, 1, pk(5, 3, 7), 0);
    vecs[3]  = v(0, 0, 0, '0, 0, 1,           0, 1, 2'd0, 0, '0, 0);
    vecs[4]  = v(0, 0, 1, mk(1), 0, 0,        0, 1, 2'd0, 0, '0, 0);
    vecs[5]  = v(0, 0, 1, mk(2), 0, 0,        1, 1, 2'd1, 1, mk(1), 0);
    vecs[6]  = v(0, 0, 1, mk(3), 0, 0,        1, 0, 2'd2, 1, mk(1), 0);
    vecs[7]  = v(0, 0, 1, mk(3), 0, 1,        1, 0, 2'd2, 1, mk(1), 0);
    vecs[8]  = v(0, 0, 1, mk(3), 0, 1,        1, 1, 2'd1, 1, mk(2), 0);
    vecs[9]  = v(0, 0, 0, '0, 0, 1,           1, 1, 2'd1, 1, mk(3), 0);
    vecs[10] = v(0, 0, 0, '0, 0, 0,           0, 1, 2'd0, 0, '0, 0);
    vecs[11] = v(0, 0, 1, mk(11), 0, 0,       0, 1, 2'd0, 0, '0, 0);
    vecs[12] = v(0, 0, 1, mk(12), 0, 0,       1, 1, 2'd1, 1, mk(11), 0);
    vecs[13] = v(0, 1, 1, mk(13), 0, 1,       1, 0, 2'd2, 1, mk(11), 0);
    vecs[14] = v(0, 0, 0, '0, 0, 1,           0, 1, 2'd0, 1, '0, 0);
    vecs[15] = v(0, 0, 1, mk(21), 1, 0,       0, 1, 2'd0, 0, '0, 0);
    vecs[16] = v(0, 0, 1, mk(22), 0, 0,       1, 1, 2'd1, 1, mk(21), 1);
    vecs[17] = v(0, 0, 0, '0, 0, 1,           1, 0, 2'd2, 1, mk(21), 1);
    vecs[18] = v(0, 0, 0, '0, 0, 1,           1, 1, 2'd1, 1, mk(22), STK);
    vecs[19] = v(0, 1, 0, '0, 0, 0,           0, 0, 2'd0, 1, mk(22), STK);
    vecs[20] = v(0, 0, 0, '0, 0, 0,           0, 1, 2'd0, 1, '0, 0);

    // First reset edge brings the state out of X; row 0 is the second reset cycle.
    drive(1, 0, 1, pk(9, 9, 9), 1, 1);
    @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].flush, vecs[i].iv, vecs[i].d, vecs[i].ovf, vecs[i].ordy);
      #1;
      chk($sformatf("row%0d out_valid", i), DW'(out_valid), DW'(vecs[i].e_ov));
      chk($sformatf("row%0d in_ready", i), DW'(in_ready), DW'(vecs[i].e_ir));
      chk($sformatf("row%0d occupancy", i), DW'(occupancy), DW'(vecs[i].e_occ));
      if (vecs[i].chk_d) begin
        chk($sformatf("row%0d out_data", i), out_data, vecs[i].e_d);
        chk($sformatf("row%0d out_overflow", i), DW'(out_overflow), DW'(vecs[i].e_oo));
      end
    end

    // Streaming: 100 back-to-back beats, each seen one cycle after acceptance.
    for (int k = 0; k <= 100; k++) begin
      @(negedge clk);
      if (k < 100) drive(0, 0, 1, pk(k + 1000, k + 500, k), 0, 1);
      else         drive(0, 0, 0, '0, 0, 1);
      #1;
      chk($sformatf("stream%0d in_ready", k), DW'(in_ready), DW'(1'b1));
      if (k > 0) begin
        chk($sformatf("stream%0d out_valid", k), DW'(out_valid), DW'(1'b1));
        chk($sformatf("stream%0d occupancy", k), DW'(occupancy), DW'(2'd1));
        chk($sformatf("stream%0d out_data", k), out_data, pk(k + 999, k + 499, k - 1));
      end
    end
    @(negedge clk);
    #1;
    chk("stream drained out_valid", DW'(out_valid), DW'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
